// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helpers for the parametrised FIFO.
package fifo_pkg;

   localparam int FIFO_DEF_WIDTH = 8;
   localparam int FIFO_DEF_DEPTH = 32;

   // Storage address width; a depth of 1 still needs one address bit.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Pointer/occupancy width: one extra bit so that count can reach DEPTH.
   function automatic int cnt_w(input int depth);
      return addr_w(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port DEPTH x WIDTH storage.
// One write port and one registered read port. Nothing here is reset.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the accepted word.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read port: on a same-slot read and write (full with rd & wr), the old word is returned.
   always_ff @(posedge clock) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count and
// programmable almost-full/almost-empty flags. All DEPTH entries are usable:
// the pointers carry a wrap bit, and count = wr_ptr - rd_ptr.
// Optional macro FIFO_PARAM_ERR_EN adds sticky overflow/underflow flags.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = FIFO_DEF_WIDTH,
   parameter int DEPTH    = FIFO_DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
`ifdef FIFO_PARAM_ERR_EN
   output logic                     overflow,
   output logic                     underflow,
`endif
   output logic [cnt_w(DEPTH)-1:0]  count
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = AW + 1;

   logic [CW-1:0]    wr_ptr;
   logic [CW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;
   logic             out_vld;
   logic [WIDTH-1:0] mem_q;

   // Occupancy and flags decode straight from the registered pointers.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_LEVEL));
   assign almost_empty = (count <= CW'(AE_LEVEL));

   // A read needs data. A write needs room, or a slot freed by a read in the same cycle.
   // At empty, rd & wr only writes: there is no fall-through.
   assign rd_ok = rd & ~empty;
   assign wr_ok = wr & (~full | rd_ok);

   // Pointer update; wrap is natural through the extra MSB.
   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock   (clock),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (data_in),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (mem_q)
   );

   // The storage read register has no reset. This bit forces data_out to 0
   // from reset until the first accepted read reloads the register.
   always_ff @(posedge clock) begin
      if (rst)        out_vld <= 1'b0;
      else if (rd_ok) out_vld <= 1'b1;
   end

   assign data_out = out_vld ? mem_q : '0;

`ifdef FIFO_PARAM_ERR_EN
   // Sticky error flags. Overflow means a refused write; underflow means a read while empty.
   always_ff @(posedge clock) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr & ~wr_ok) overflow  <= 1'b1;
         if (rd & empty)  underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed stimulus for fifo_param (WIDTH=8, DEPTH=16, AF=12, AE=4).
// Accepted reads push their expected word into a scoreboard queue. A monitor
// pops that queue and compares data_out one cycle later. Flags and count are
// checked every cycle against a small reference queue.
module tb_fifo_param;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int AF = 12;
   localparam int AE = 4;

   logic         clock = 1'b0;
   logic         rst   = 1'b1;
   logic         wr    = 1'b0;
   logic         rd    = 1'b0;
   logic [W-1:0] data_in = '0;
   logic [W-1:0] data_out;
   logic         full, empty, almost_full, almost_empty;
   logic [4:0]   count;
`ifdef FIFO_PARAM_ERR_EN
   logic         overflow, underflow;
`endif

   fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clock        (clock),
      .rst          (rst),
      .wr           (wr),
      .rd           (rd),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
`ifdef FIFO_PARAM_ERR_EN
      .overflow     (overflow),
      .underflow    (underflow),
`endif
      .count        (count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] q_m[$];     // reference contents
   logic [W-1:0] exp_q[$];   // scoreboard of expected read data
   logic [W-1:0] out_m = '0;
   bit           ovf_m = 0, unf_m = 0;
   bit           rd_exp = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a read accepted at a posedge is checked on the following negedge.
   initial begin
      bit took;
      forever begin
         @(posedge clock);
         took = rd_exp;
         @(negedge clock);
         if (took) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL scoreboard: read seen with no expected data");
            end else begin
               chk("read_data", int'(data_out), int'(exp_q.pop_front()));
            end
         end
      end
   end

   // One clock of stimulus: drive, update the reference, then check the state after the edge.
   task automatic cycle(input bit r_st, input bit w, input bit r, input logic [W-1:0] d);
      bit rok, wok;
      rst = r_st; wr = w; rd = r; data_in = d;
      if (r_st) begin
         q_m.delete(); out_m = '0; ovf_m = 0; unf_m = 0; rd_exp = 0;
      end else begin
         rok = r && (q_m.size() > 0);
         wok = w && ((q_m.size() < D) || rok);
         if (w && !wok) ovf_m = 1;
         if (r && q_m.size() == 0) unf_m = 1;
         if (rok) begin
            out_m = q_m.pop_front();
            exp_q.push_back(out_m);
         end
         if (wok) q_m.push_back(d);
         rd_exp = rok;
      end
      @(posedge clock);
      @(negedge clock);
      chk("count", int'(count), q_m.size());
      chk("empty", int'(empty), int'(q_m.size() == 0));
      chk("full", int'(full), int'(q_m.size() == D));
      chk("almost_full", int'(almost_full), int'(q_m.size() >= AF));
      chk("almost_empty", int'(almost_empty), int'(q_m.size() <= AE));
      if (!rd_exp) chk("data_hold", int'(data_out), int'(out_m));
`ifdef FIFO_PARAM_ERR_EN
      chk("overflow", int'(overflow), int'(ovf_m));
      chk("underflow", int'(underflow), int'(unf_m));
`endif
   endtask

   // Watchdog: stimulus never waits on the DUT, but bound the run anyway.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      // Reset for two cycles with wr and rd asserted; reset overrides both.
      cycle(1, 1, 1, 8'hEE);
      cycle(1, 1, 1, 8'hEE);
      chk("reset_count", int'(count), 0);
      chk("reset_data_out", int'(data_out), 8'h00);

      // Fill with 0x01..0x10. almost_full rises at 12 and full at 16.
      for (int i = 1; i <= D; i++) begin
         cycle(0, 1, 0, W'(i));
         if (i == 11) chk("af_below", int'(almost_full), 0);
         if (i == 12) chk("af_at_12", int'(almost_full), 1);
      end
      chk("full_at_16", int'(full), 1);
      cycle(0, 1, 0, 8'hFF);                 // refused
      chk("refused_count", int'(count), 16);

      // At full, rd & wr: read 0x01, store 0xAA, and stay full.
      cycle(0, 1, 1, 8'hAA);
      chk("full_sim_data", int'(data_out), 8'h01);
      chk("full_sim_count", int'(count), 16);
      for (int i = 0; i < D; i++) cycle(0, 0, 1, '0);   // 0x02..0x10, then 0xAA
      chk("drain_last", int'(data_out), 8'hAA);

      // At empty, rd & wr: only the write is accepted and data_out holds.
      cycle(0, 1, 1, 8'h55);
      chk("empty_sim_hold", int'(data_out), 8'hAA);
      chk("empty_sim_count", int'(count), 1);
      cycle(0, 0, 1, '0);
      chk("empty_sim_read", int'(data_out), 8'h55);

      // Wrap: reset, then 40 write/read pairs. The pointers pass 16 and 32.
      cycle(1, 0, 0, '0);
      for (int k = 0; k < 40; k++) begin
         cycle(0, 1, 0, W'(k + 8'h20));
         cycle(0, 0, 1, '0);
      end
      chk("wrap_last", int'(data_out), 8'h20 + 39);

      // Reset mid-operation at count 9 discards all contents.
      for (int i = 0; i < 9; i++) cycle(0, 1, 0, W'(8'h90 + i));
      chk("pre_reset_count", int'(count), 9);
      cycle(1, 0, 0, '0);
      chk("mid_reset_empty", int'(empty), 1);
      cycle(0, 1, 0, 8'h33);
      cycle(0, 0, 1, '0);
      chk("post_reset_read", int'(data_out), 8'h33);

      cycle(0, 0, 0, '0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the single-clock 8-bit byte FIFO. It generalises data width and depth and makes all DEPTH entries usable. It adds an occupancy count, programmable almost-full/almost-empty flags, and defined behaviour for simultaneous read/write at the full and empty boundaries. It sits between a producer and a consumer in the same clock domain, as a drop-in buffer for the existing FIFO users.

## Interface
Parameters:
- WIDTH, 8: data word width in bits, ≥1
- DEPTH, 32: number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-4: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1

Ports:
- clock  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr  in  1  write request
- rd  in  1  read request
- data_in  in  WIDTH  write data, sampled when the write is accepted
- data_out  out  WIDTH  registered read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky; present only with FIFO_PARAM_ERR_EN
- underflow  out  1  sticky; present only with FIFO_PARAM_ERR_EN

## Operation
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the low bits address storage.
  - The MSB is a wrap bit. count = wr_ptr − rd_ptr, computed modulo 2^(AW+1).
  - Pointers wrap naturally. No entry is sacrificed; full means exactly DEPTH entries are stored.
- Write acceptance: wr_ok = wr & (~full | rd_ok).
- Read acceptance: rd_ok = rd & ~empty.
- Simultaneous rd & wr:
  - When full, both are accepted and count stays at DEPTH.
  - When empty, only the write is accepted (no fall-through). data_out holds its value.
- Accepted write stores data_in at mem[wr_ptr] and increments wr_ptr.
- Accepted read loads mem[rd_ptr] into data_out and increments rd_ptr.
- data_out holds its value when no read is accepted. Storage contents are never reset.
- A refused request has no effect on pointers, memory or data_out.
- Reset:
  - wr_ptr, rd_ptr, count and data_out are cleared to 0.
  - empty=1, full=0, almost_empty=1 (AE_LEVEL≥0), almost_full=0, overflow=0, underflow=0.
  - rst overrides any wr/rd in the same cycle. Reset mid-operation discards all contents.

## Timing
- All outputs are registered or decoded directly from registered pointers. No combinational path from wr/rd to any output.
- Read latency: 1 cycle. data_out is valid on the edge after rd is sampled with empty=0.
- Write-to-read latency: a word written at edge N is readable from edge N+1 (empty falls after edge N). It appears on data_out after edge N+2 if rd is high at N+1.
- count, full, empty, almost_* update on the same edge as the accepted operation.

## Configuration
- FIFO_PARAM_ERR_EN defined:
  - overflow sets when wr=1 and the write is refused.
  - underflow sets when rd=1 and empty=1.
  - Both flags are sticky until rst.
- FIFO_PARAM_ERR_EN undefined: the overflow and underflow ports and their logic are absent. All other behaviour is identical.

## Structure
- Package fifo_pkg:
  - function for address width ($clog2 wrapper)
  - count width helper
  - default parameter constants (FIFO_DEF_WIDTH=8, FIFO_DEF_DEPTH=32)
- Sub-module fifo_mem:
  - simple dual-port storage, DEPTH×WIDTH, one write port and one registered read port
  - read-enable input; no reset
- fifo_param holds the pointers, flag and count logic, and error flags.

## Test plan
All scenarios use WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4.
- Reset: drive rst for 2 cycles with wr=rd=1 -> count=0, empty=1, full=0, almost_empty=1, data_out=0x00.
- Fill: write 0x01..0x10 with rd=0 -> almost_full rises when count reaches 12, full=1 at count=16. A 17th write with 0xFF is refused and overflow=1 (ERR_EN). Draining returns 0x01..0x10 in order, each 1 cycle after its rd.
- Full simultaneous: at full, drive wr=1 (0xAA) with rd=1 -> data_out=0x01, count stays 16, full stays 1. 0xAA is read 16th.
- Empty simultaneous: at empty, drive wr=1 (0x55) with rd=1 -> write accepted, data_out unchanged, count=1, underflow=1 (ERR_EN). Next cycle rd -> data_out=0x55.
- Wrap: run 40 alternating write/read pairs with an incrementing pattern -> count toggles 0/1, data matches, pointers wrap past 16 and 32 without error flags.
- Mid-operation reset: at count=9, pulse rst -> next cycle count=0, empty=1. A subsequent write of 0x33 followed by a read returns 0x33.
